// File: rtl/quad_decoder.sv
// A/B quadrature decoder: 2-FF resync, optional stability filter (QDEC_FILTER_EN),
// x4 decode into a signed 32-bit position with preset and a sticky illegal-transition flag.

module qdec_chan
`ifdef QDEC_FILTER_EN
#(
   parameter int FILTER_LEN = 4
)
`endif
(
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic i_raw,
   output logic o_val
);

   logic [1:0] r_sync;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) r_sync <= '0;
      else            r_sync <= {r_sync[0], i_raw};
   end

`ifdef QDEC_FILTER_EN
   logic [3:0] r_cnt;
   logic       r_filt;

   // Counts consecutive cycles the synchronised input disagrees with the
   // accepted level; a run shorter than FILTER_LEN never gets through.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_cnt  <= '0;
         r_filt <= 1'b0;
      end else if (r_sync[1] == r_filt) begin
         r_cnt  <= '0;
      end else if (r_cnt == 4'(FILTER_LEN - 1)) begin
         r_filt <= r_sync[1];
         r_cnt  <= '0;
      end else begin
         r_cnt  <= r_cnt + 4'd1;
      end
   end

   assign o_val = r_filt;
`else
   assign o_val = r_sync[1];
`endif

endmodule

module quad_decoder #(
   parameter int FILTER_LEN = 4
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        a_i,
   input  logic        b_i,
   input  logic        enable_i,
   input  logic [31:0] setp_val_i,
   input  logic        setp_wstb_i,
   input  logic        err_clr_i,
   output logic [31:0] posn_o,
   output logic        dir_o,
   output logic        step_o,
   output logic        err_o
);

`ifdef QDEC_FILTER_EN
   localparam bit FILT_EN = 1'b1;
`else
   localparam bit FILT_EN = 1'b0;
`endif
   localparam int FLT_STAGES = FILT_EN ? FILTER_LEN : 0;
   // Priming waits until the post-reset input level has crossed the
   // synchroniser (and filter), so a non-00 level at release is not a step.
   localparam int SETTLE     = 2 + FLT_STAGES;

   typedef enum logic {
      UNPRIMED = 1'b0,
      RUN      = 1'b1
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [4:0]  r_settle;
   logic [1:0]  r_prev;
   logic [31:0] r_posn;
   logic        r_dir, r_step, r_err;

   logic [1:0]  w_raw, w_cur, w_delta;
   logic        w_load_prev, w_valid, w_up, w_illegal;

   assign w_raw = {a_i, b_i};

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_chan
`ifdef QDEC_FILTER_EN
         qdec_chan #(.FILTER_LEN(FILTER_LEN)) u_chan (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .i_raw     (w_raw[g]),
            .o_val     (w_cur[g])
         );
`else
         qdec_chan u_chan (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .i_raw     (w_raw[g]),
            .o_val     (w_cur[g])
         );
`endif
      end
   endgenerate

   // Position of an {A,B} code along the forward cycle 00,10,11,01.
   function automatic logic [1:0] phase_idx(input logic [1:0] ab);
      case (ab)
         2'b00:   phase_idx = 2'd0;
         2'b10:   phase_idx = 2'd1;
         2'b11:   phase_idx = 2'd2;
         default: phase_idx = 2'd3;
      endcase
   endfunction

   // Mod-4 phase distance: 1 = forward, 3 = reverse, 2 = both bits flipped.
   assign w_delta = phase_idx(w_cur) - phase_idx(r_prev);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state  <= UNPRIMED;
         r_settle <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == UNPRIMED && r_settle != 5'(SETTLE))
            r_settle <= r_settle + 5'd1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load_prev = 1'b0;
      w_valid     = 1'b0;
      w_up        = 1'b0;
      w_illegal   = 1'b0;
      case (r_state)
         UNPRIMED: begin
            if (r_settle == 5'(SETTLE)) begin
               w_load_prev = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_load_prev = 1'b1;
            case (w_delta)
               2'd1: begin
                  w_valid = 1'b1;
                  w_up    = 1'b1;
               end
               2'd3:    w_valid   = 1'b1;
               2'd2:    w_illegal = 1'b1;
               default: ;
            endcase
         end
         default: w_state_nxt = UNPRIMED;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_prev <= 2'b00;
         r_posn <= '0;
         r_dir  <= 1'b0;
         r_step <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_step <= 1'b0;
         if (w_load_prev) r_prev <= w_cur;
         if (w_valid && enable_i) begin
            r_step <= 1'b1;
            r_dir  <= w_up;
            r_posn <= w_up ? r_posn + 32'd1 : r_posn - 32'd1;
         end
         // Preset overrides any count in the same cycle.
         if (setp_wstb_i) r_posn <= setp_val_i;
         if (w_illegal)      r_err <= 1'b1;
         else if (err_clr_i) r_err <= 1'b0;
      end
   end

   assign posn_o = r_posn;
   assign dir_o  = r_dir;
   assign step_o = r_step;
   assign err_o  = r_err;

endmodule
